// File: rtl/fft_bitrev_reorder_64.sv
// rtl/fft_bitrev_reorder_64.sv - ping-pong natural-to-bit-reversed frame reorder ahead of fft_64_top
// Optional: FFT_REORDER_PRESCALE_EN arithmetic-shifts each sample right by LOG2N before storage.
module fft_bitrev_reorder_64 #(
  parameter int WIDTH = 32,
  parameter int N     = 64,
  parameter int LOG2N = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    input_en,
  input  logic signed [WIDTH-1:0] input_real,
  input  logic signed [WIDTH-1:0] input_imag,
  output logic                    output_en,
  output logic signed [WIDTH-1:0] output_real,
  output logic signed [WIDTH-1:0] output_imag
);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  state_t state_q, state_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
  logic wr_bank_q, wr_bank_d;
  logic out_en_q, out_en_d;
  logic signed [WIDTH-1:0] out_real_q, out_real_d;
  logic signed [WIDTH-1:0] out_imag_q, out_imag_d;

  logic [2*WIDTH-1:0] mem [0:1][0:N-1];
  logic [2*WIDTH-1:0] rd_word;
  logic signed [WIDTH-1:0] wr_real, wr_imag;
  logic frame_done;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    for (int i = 0; i < LOG2N; i++) begin
      bitrev[i] = a[LOG2N-1-i];
    end
  endfunction

`ifdef FFT_REORDER_PRESCALE_EN
  assign wr_real = input_real >>> LOG2N;
  assign wr_imag = input_imag >>> LOG2N;
`else
  assign wr_real = input_real;
  assign wr_imag = input_imag;
`endif

  assign frame_done = input_en && (wr_cnt_q == LAST);
  assign rd_word    = mem[~wr_bank_q][bitrev(rd_cnt_q)];

  // Sample storage carries no reset; stale contents are never read before a full frame lands.
  always_ff @(posedge clock) begin
    if (input_en) begin
      mem[wr_bank_q][wr_cnt_q] <= {wr_real, wr_imag};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      out_en_q   <= 1'b0;
      out_real_q <= '0;
      out_imag_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_bank_q  <= wr_bank_d;
      out_en_q   <= out_en_d;
      out_real_q <= out_real_d;
      out_imag_q <= out_imag_d;
    end
  end

  // A frame completing on the last read edge keeps READ alive so bursts stay seamless.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (frame_done) state_d = READ;
      READ: if (rd_cnt_q == LAST && !frame_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    rd_cnt_d   = rd_cnt_q;
    out_en_d   = 1'b0;
    out_real_d = out_real_q;
    out_imag_d = out_imag_q;
    if (input_en) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
    if (frame_done) begin
      wr_bank_d = ~wr_bank_q;
    end
    if (state_q == READ) begin
      out_en_d   = 1'b1;
      out_real_d = rd_word[2*WIDTH-1:WIDTH];
      out_imag_d = rd_word[WIDTH-1:0];
      rd_cnt_d   = rd_cnt_q + 1'b1;
    end
    if (frame_done) begin
      rd_cnt_d = '0;
    end
  end

  assign output_en   = out_en_q;
  assign output_real = out_real_q;
  assign output_imag = out_imag_q;

endmodule

// File: doc/fft_bitrev_reorder_64.md
# fft_bitrev_reorder_64

Input reordering stage placed directly upstream of `fft_64_top` (radix-2 SDF, 64-point). It accepts complex samples in natural time order and re-emits each 64-sample frame in bit-reversed order, the order `fft_64_top` consumes. It uses a ping-pong buffer, so one frame is written while the previous frame is read out. Back-to-back input frames therefore produce a continuous output stream.

## Interface
- `WIDTH`, 32, signed sample width of the real and imaginary parts.
- `N`, 64, frame length.
- `LOG2N`, 6, address width. `N` must equal `2**LOG2N`.

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `input_en`  in  1  qualifies `input_real`/`input_imag` on this edge.
- `input_real`  in  WIDTH  signed real sample, natural order.
- `input_imag`  in  WIDTH  signed imaginary sample, natural order.
- `output_en`  out  1  qualifies output sample; connects to `fft_64_top.input_en`.
- `output_real`  out  WIDTH  signed real sample, bit-reversed order.
- `output_imag`  out  WIDTH  signed imaginary sample, bit-reversed order.

## Operation
- **Storage:** two banks, each N x 2·WIDTH. Register `wr_bank` selects the bank being filled; the read bank is `~wr_bank`.
- **Write side:**
  - On each edge with `input_en`=1, store the sample at `mem[wr_bank][wr_cnt]` and increment `wr_cnt` (LOG2N bits).
  - Gaps in `input_en` are allowed and stall `wr_cnt`.
- **Frame complete:** when a write occurs with `wr_cnt`==N-1:
  - `wr_cnt` wraps to 0 and `wr_bank` toggles.
  - `rd_active` is set and `rd_cnt` is cleared to 0 on the same edge.
- **Read side (states IDLE / READ):**
  - In READ, each edge registers `output_real`/`output_imag` from `mem[~wr_bank][bitrev(rd_cnt)]`, sets `output_en`=1 and increments `rd_cnt`.
  - `bitrev` reverses all LOG2N bits, e.g. 1→32, 2→16, 3→48.
  - After the read with `rd_cnt`==N-1, return to IDLE, unless a new frame completed on that same edge; in that case stay in READ with `rd_cnt`=0 and the swapped bank.
- **In IDLE:** `output_en`=0. `output_real`/`output_imag` hold their last values and are don't-care.
- **No overrun by construction:** a frame needs ≥N write edges and a readout takes exactly N edges, so no overrun is possible. The bench asserts that frame-complete never occurs while `rd_cnt`≠N-1 in READ.
- **Reset:**
  - Clears `wr_cnt`, `rd_cnt`, `wr_bank`, `rd_active`, `output_en`, `output_real` and `output_imag` to 0 immediately.
  - Any partial frame or in-progress readout is discarded. Memory contents are not reset.

## Timing
- **Reset values:** `output_en`=0, `output_real`=0, `output_imag`=0.
- **Latency:** the 64th input sample is written at edge E0. The first output (index bitrev(0)=0) is valid after edge E1, and the last output (index 63) after edge E64.
- **Burst shape:** `output_en` is high for exactly N consecutive cycles per frame, with no gaps, regardless of input gaps.
- **Back-to-back frames:** with contiguous input, frame k+1 completes at E64. Output stays high continuously, with frame k+1's first sample valid after E65.
- **Reset timing:** asserting reset mid-frame forces `output_en` low asynchronously. The first frame after release must be a full N samples counted from the first `input_en` after release.

## Configuration
- **`FFT_REORDER_PRESCALE_EN`**
  - Defined: each sample is arithmetically shifted right by LOG2N (sign-extended, floor) before being stored. This pre-compensates the FFT's bit growth.
  - Undefined: samples are stored unmodified.
  - Read order and timing are identical in both cases.

## Test plan
- **Order check:** contiguous ramp `input_real`=k, `input_imag`=0, k=0..63 → outputs 0,32,16,48,8,40,…,63, imag 0. `output_en` rises one cycle after the 64th input and stays high 64 cycles.
- **Back-to-back frames:** ramp k, then ramp 100+k, contiguous → 128 consecutive `output_en` cycles. The second half is 100,132,116,148,….
- **Gapped input:** `input_en` on alternate cycles with ramp k → same bit-reversed sequence. `output_en` starts one cycle after the last accepted sample and is contiguous for 64 cycles.
- **Reset mid-frame:** reset pulsed after 30 samples, then a fresh ramp 200+k → outputs 0 and `output_en`=0 during reset. Only the 64 fresh samples emerge: 200,232,216,….
- **Imaginary path:** `input_imag`=−k, `input_real`=k → `output_imag` = −bitrev(k), e.g. index 1 gives −32.
- **Prescale:** with `FFT_REORDER_PRESCALE_EN`, inputs 6400, −1, −64, 63 → stored/output values 100, −1, −1, 0 at their bit-reversed positions.
